seq_chunk_adder: RTL and testbench

//   Multi-cycle, parametrised ripple adder. It adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, LSB chunk first.
//   A carry register links the chunks, so area is bounded by one CHUNK-bit adder.
//   It has valid/ready handshakes on input and output, and sits between operand sources and result consumers in datapath blocks.

---
 rtl/seq_chunk_adder_if.sv | 48 ++++
 rtl/seq_chunk_adder.sv | 140 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if
//   Operand/result bundle for seq_chunk_adder.
//   Optional feature macro: SUB_MODE_EN (adds the sub control bit).
//   Signals:
//     in_valid, in_ready  operand handshake
//     a, b, cin           operands and carry-in
//     sub                 subtract select (SUB_MODE_EN builds only)
//     out_valid, out_ready result handshake
//     sum, cout           result and carry-out
//   Modports:
//     master  operand source / result consumer
//     slave   the adder itself
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SUB_MODE_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SUB_MODE_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle ripple adder: adds a + b + cin, CHUNK bits per clock,
//   least significant chunk first, with a carry register linking chunks.
//   Optional feature macro: SUB_MODE_EN (when defined, bus.sub=1 computes
//   a + ~b + 1 and ignores cin; cout=1 then means no borrow).
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous reset, active-high
//     bus   seq_chunk_adder_if.slave: operand handshake (in_valid/in_ready,
//           a, b, cin[, sub]) and result handshake (out_valid/out_ready,
//           sum, cout)
//   Parameters:
//     WIDTH  operand/sum width, a multiple of CHUNK
//     CHUNK  bits added per cycle, 1..WIDTH
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic            clk,
    input logic            rst,
    seq_chunk_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;

    logic [CHUNK:0]         chunk_res;
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic [WIDTH+CHUNK-1:0] a_cat;
    logic [WIDTH+CHUNK-1:0] b_cat;
    logic [WIDTH-1:0]       res_next;
    logic [WIDTH-1:0]       a_next;
    logic [WIDTH-1:0]       b_next;
    logic [WIDTH-1:0]       b_load;
    logic                   c_load;
    logic                   accept;

    // One CHUNK-bit add with carry-in; the top bit is the chunk carry-out.
    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Subtraction is folded in at load time: invert b and force the
    // carry-in to 1, so the run phase is identical for both operations.
`ifdef SUB_MODE_EN
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load = bus.b;
    assign c_load = bus.cin;
`endif

    // Concatenate-and-slice rather than >> so that CHUNK == WIDTH still
    // elaborates without zero-width replications.
    always_comb begin
        chunk_res = chunk_add(a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], carry);
        res_cat   = {chunk_res[CHUNK-1:0], res_sh};
        a_cat     = {{CHUNK{1'b0}}, a_sh};
        b_cat     = {{CHUNK{1'b0}}, b_sh};
        res_next  = res_cat[WIDTH+CHUNK-1:CHUNK];
        a_next    = a_cat[WIDTH+CHUNK-1:CHUNK];
        b_next    = b_cat[WIDTH+CHUNK-1:CHUNK];
    end

    // Operand and partial-result shift registers; fully overwritten by
    // every operation, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= bus.a;
            b_sh <= b_load;
        end else if (state == RUN) begin
            a_sh   <= a_next;
            b_sh   <= b_next;
            res_sh <= res_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= c_load;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= chunk_res[CHUNK];
                    if (cnt == LAST) begin
                        sum_q       <= res_next;
                        cout_q      <= chunk_res[CHUNK];
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_t;
    logic [15:0] b_t;
    logic        cin_t;
    logic        sub_t;
    logic        ordy;
    logic        iv [3];

    logic        ov [3];
    logic        ir [3];
    logic [15:0] sm [3];
    logic        co [3];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Three builds of the adder: CHUNK=4 (main), CHUNK=16, CHUNK=1.
    seq_chunk_adder_if #(.WIDTH(16)) bus0 ();
    seq_chunk_adder_if #(.WIDTH(16)) bus1 ();
    seq_chunk_adder_if #(.WIDTH(16)) bus2 ();

    assign bus0.in_valid = iv[0];
    assign bus0.a = a_t;
    assign bus0.b = b_t;
    assign bus0.cin = cin_t;
    assign bus0.out_ready = ordy;
    assign bus1.in_valid = iv[1];
    assign bus1.a = a_t;
    assign bus1.b = b_t;
    assign bus1.cin = cin_t;
    assign bus1.out_ready = ordy;
    assign bus2.in_valid = iv[2];
    assign bus2.a = a_t;
    assign bus2.b = b_t;
    assign bus2.cin = cin_t;
    assign bus2.out_ready = ordy;
`ifdef SUB_MODE_EN
    assign bus0.sub = sub_t;
    assign bus1.sub = sub_t;
    assign bus2.sub = sub_t;
`endif

    assign ov[0] = bus0.out_valid;
    assign ir[0] = bus0.in_ready;
    assign sm[0] = bus0.sum;
    assign co[0] = bus0.cout;
    assign ov[1] = bus1.out_valid;
    assign ir[1] = bus1.in_ready;
    assign sm[1] = bus1.sum;
    assign co[1] = bus1.cout;
    assign ov[2] = bus2.out_valid;
    assign ir[2] = bus2.in_ready;
    assign sm[2] = bus2.sum;
    assign co[2] = bus2.cout;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for in_ready, accept, then count cycles until
    // out_valid and compare the result. Leaves the DUT in DONE.
    task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input logic s, input int nch,
                          input logic [15:0] esum, input logic ecout, input string tag);
        int n;
        a_t   = av;
        b_t   = bv;
        cin_t = c;
        sub_t = s;
        n = 0;
        while (!ir[k] && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(ir[k]), 32'd1);
        iv[k] = 1'b1;
        tick();
        iv[k] = 1'b0;
        n = 0;
        while (!ov[k] && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(nch));
        check({tag, "_sum"}, 32'(sm[k]), 32'(esum));
        check({tag, "_cout"}, 32'(co[k]), 32'(ecout));
    endtask

    // With out_ready held high, out_valid must last exactly one cycle.
    task automatic check_drop(input int k, input string tag);
        tick();
        check({tag, "_pulse"}, 32'(ov[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        rst   = 1'b1;
        ordy  = 1'b1;
        a_t   = '0;
        b_t   = '0;
        cin_t = 1'b0;
        sub_t = 1'b0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_out_valid", 32'(ov[0]), 32'd0);
            check("rst_sum", 32'(sm[0]), 32'd0);
            check("rst_cout", 32'(co[0]), 32'd0);
            check("rst_in_ready", 32'(ir[0]), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(ir[0]), 32'd1);

        // Basic add and single-cycle out_valid
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 4, 16'h5555, 1'b0, "add");
        check_drop(0, "add");

        // Full carry ripple
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 16'h0000, 1'b1, "ripple1");
        check_drop(0, "ripple1");
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4, 16'hFFFF, 1'b1, "ripple2");
        check_drop(0, "ripple2");

        // Backpressure with in_valid pulses that must be ignored
        ordy = 1'b0;
        run_op(0, 16'h0F0F, 16'h0101, 1'b1, 1'b0, 4, 16'h1011, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            iv[0] = (i % 2 == 0);
            a_t   = 16'hFFFF;
            b_t   = 16'hFFFF;
            tick();
            check("bp_hold_valid", 32'(ov[0]), 32'd1);
            check("bp_hold_sum", 32'(sm[0]), 32'h1011);
            check("bp_hold_cout", 32'(co[0]), 32'd0);
            check("bp_in_ready", 32'(ir[0]), 32'd0);
        end
        iv[0] = 1'b0;
        ordy  = 1'b1;
        tick();
        check("bp_release_valid", 32'(ov[0]), 32'd0);
        check("bp_release_idle", 32'(ir[0]), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov[0]) seen = 1;
        end
        check("bp_no_queued_op", 32'(seen), 32'd0);
        check("bp_sum_kept_idle", 32'(sm[0]), 32'h1011);

        // Reset during the second RUN cycle
        a_t   = 16'h00FF;
        b_t   = 16'h0001;
        cin_t = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_out_valid", 32'(ov[0]), 32'd0);
        check("abort_sum", 32'(sm[0]), 32'd0);
        check("abort_cout", 32'(co[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(ir[0]), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov[0]) seen = 1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 4, 16'h5555, 1'b0, "rerun");
        check_drop(0, "rerun");

`ifdef SUB_MODE_EN
        // Subtraction; cin must be ignored
        run_op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, 4, 16'h0002, 1'b1, "sub_nb");
        check_drop(0, "sub_nb");
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 4, 16'hFFFE, 1'b0, "sub_borrow");
        check_drop(0, "sub_borrow");
        sub_t = 1'b0;
`endif

        // Chunk extremes: one RUN cycle and sixteen RUN cycles
        run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 16'h5555, 1'b0, "chunk16");
        check_drop(1, "chunk16");
        run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b0, 16, 16'h5555, 1'b0, "chunk1");
        check_drop(2, "chunk1");
        run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16, 16'h0000, 1'b1, "chunk1_ripple");
        check_drop(2, "chunk1_ripple");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
